// File: rtl/gate_pkg.sv
// Shared definitions for the gate library: operation codes used by the logic units.
package gate_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND     = 3'd0;
  localparam logic [OP_W-1:0] OP_OR      = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR     = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND    = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR     = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR    = 3'd5;
  localparam logic [OP_W-1:0] OP_PASS    = 3'd6;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

endpackage

// File: rtl/gate_reduce.sv
// Combinational multi-operand bitwise reduction with per-operand enables.
module gate_reduce
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 3
) (
  input  logic [OP_W-1:0]         op_i,
  input  logic [NUM_IN-1:0]       mask_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]        z_o,
  output logic                    err_o
);

  logic [WIDTH-1:0] and_acc;
  logic [WIDTH-1:0] or_acc;
  logic [WIDTH-1:0] xor_acc;

  // Disabled operands contribute the identity of each reduction, so skipping them is enough.
  always_comb begin
    and_acc = '1;
    or_acc  = '0;
    xor_acc = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (mask_i[k]) begin
        and_acc = and_acc & data_i[k*WIDTH +: WIDTH];
        or_acc  = or_acc  | data_i[k*WIDTH +: WIDTH];
        xor_acc = xor_acc ^ data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    z_o   = '0;
    err_o = 1'b0;
    case (op_i)
      OP_AND:  z_o = and_acc;
      OP_OR:   z_o = or_acc;
      OP_XOR:  z_o = xor_acc;
      OP_NAND: z_o = ~and_acc;
      OP_NOR:  z_o = ~or_acc;
      OP_XNOR: z_o = ~xor_acc;
      OP_PASS: z_o = data_i[WIDTH-1:0];
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_pipe.sv
// Two-stage valid/ready pipelined logic unit: S1 captures the request, S2 holds the result.
module gate_pipe
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_op,
  input  logic [NUM_IN-1:0]       in_mask,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_z,
  output logic                    out_err,
  output logic [CNT_W-1:0]        done_cnt
);

  logic                    s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]         s1_op_q, s1_op_d;
  logic [NUM_IN-1:0]       s1_mask_q, s1_mask_d;
  logic [NUM_IN*WIDTH-1:0] s1_data_q, s1_data_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]        s2_z_q, s2_z_d;
  logic                    s2_err_q, s2_err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic             s2_free;
  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] red_z;
  logic             red_err;

  gate_reduce #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_reduce (
    .op_i   (s1_op_q),
    .mask_i (s1_mask_q),
    .data_i (s1_data_q),
    .z_o    (red_z),
    .err_o  (red_err)
  );

  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
  end

  // S1 payload only loads on an accepted transfer, so idle X on the inputs never enters.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_mask_d  = s1_mask_q;
    s1_data_d  = s1_data_q;
    if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_mask_d  = in_mask;
      s1_data_d  = in_data;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_z_d     = s2_z_q;
    s2_err_d   = s2_err_q;
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_z_d   = red_z;
        s2_err_d = red_err;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_mask_q  <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_z_q     <= '0;
      s2_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_mask_q  <= s1_mask_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_z_q     <= s2_z_d;
      s2_err_q   <= s2_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_z     = s2_z_q;
  assign out_err   = s2_err_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_gate_pipe.sv
// Scoreboard bench for gate_pipe: directed stimulus queues expected results, a monitor checks them.
module tb_gate_pipe;
  import gate_pkg::*;

  localparam int unsigned W = 5;
  localparam int unsigned N = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready, in_ready2;
  logic [2:0]     in_op;
  logic [N-1:0]   in_mask;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_valid2;
  logic           out_ready;
  logic [W-1:0]   out_z, out_z2;
  logic           out_err, out_err2;
  logic [7:0]     done_cnt;
  logic [1:0]     done_cnt2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [W:0] exp_q[$];
  int pop_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_pipe #(.WIDTH(W), .NUM_IN(N), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_mask   (in_mask),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_err   (out_err),
    .done_cnt  (done_cnt)
  );

  // Narrow counter copy to exercise saturation.
  gate_pipe #(.WIDTH(W), .NUM_IN(N), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_op     (in_op),
    .in_mask   (in_mask),
    .in_data   (in_data),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_z     (out_z2),
    .out_err   (out_err2),
    .done_cnt  (done_cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops on each output transfer and checks hold-stability during stalls.
  initial begin
    logic           prev_stall;
    logic [W-1:0]   prev_z;
    logic           prev_err;
    logic [W:0]     e;
    prev_stall = 1'b0;
    prev_z     = '0;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_z", 32'(out_z), 32'(prev_z));
          check("stall_err", 32'(out_err), 32'(prev_err));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got z=%b with empty scoreboard", out_z);
          end else begin
            e = exp_q.pop_front();
            check("result_z", 32'(out_z), 32'(e[W:1]));
            check("result_err", 32'(out_err), 32'(e[0]));
            pop_cyc.push_back(cyc);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_z     = out_z;
        prev_err   = out_err;
      end
    end
  end

  task automatic idle();
    in_valid = 1'b0;
    in_op    = 'x;
    in_mask  = 'x;
    in_data  = 'x;
  endtask

  task automatic send(input logic [2:0] op, input logic [N-1:0] mask, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] c, input logic [W-1:0] ez,
                      input logic ee);
    logic fire;
    in_valid = 1'b1;
    in_op    = op;
    in_mask  = mask;
    in_data  = {c, b, a};
    fire     = 1'b0;
    for (int i = 0; i < 50 && !fire; i++) begin
      @(negedge clk);
      fire = in_ready;
      if (fire) exp_q.push_back({ez, ee});
      @(posedge clk);
      #1;
    end
    if (!fire) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle();
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_z", 32'(out_z), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic OR, with latency checks
    send(OP_OR, 3'b111, 5'b10100, 5'b00011, 5'b01000, 5'b11111, 1'b0);
    idle();
    @(negedge clk);
    check("latency_s1_only", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    check("done_cnt_1", 32'(done_cnt), 32'd1);
    check("done_cnt2_1", 32'(done_cnt2), 32'd1);

    send(OP_XOR, 3'b101, 5'b10100, 5'b11111, 5'b01000, 5'b11100, 1'b0);
    send(OP_NAND, 3'b111, 5'b11111, 5'b11110, 5'b11111, 5'b00001, 1'b0);
    idle();
    wait_drain();
    check("done_cnt_3", 32'(done_cnt), 32'd3);
    check("done_cnt2_sat3", 32'(done_cnt2), 32'd3);

    // Back-to-back burst of six
    send(OP_AND, 3'b111, 5'b11110, 5'b01111, 5'b11011, 5'b01010, 1'b0);
    send(OP_OR, 3'b011, 5'b00001, 5'b00100, 5'b10000, 5'b00101, 1'b0);
    send(OP_XNOR, 3'b111, 5'b10101, 5'b01010, 5'b00000, 5'b00000, 1'b0);
    send(OP_NOR, 3'b110, 5'b11111, 5'b00001, 5'b00010, 5'b11100, 1'b0);
    send(OP_XOR, 3'b111, 5'b11000, 5'b01100, 5'b00110, 5'b10010, 1'b0);
    send(OP_PASS, 3'b111, 5'b00111, 5'b11111, 5'b11111, 5'b00111, 1'b0);
    idle();
    wait_drain();
    n = pop_cyc.size();
    check("burst_count", 32'(n), 32'd9);
    if (n >= 6) check("burst_consecutive", 32'(pop_cyc[n-1] - pop_cyc[n-6]), 32'd5);
    check("done_cnt_9", 32'(done_cnt), 32'd9);
    check("done_cnt2_no_wrap", 32'(done_cnt2), 32'd3);

    // Illegal op and empty-mask identities
    send(OP_ILLEGAL, 3'b111, 5'b10101, 5'b01010, 5'b11111, 5'b00000, 1'b1);
    send(OP_AND, 3'b000, 5'b00000, 5'b01010, 5'b10101, 5'b11111, 1'b0);
    send(OP_NOR, 3'b000, 5'b11111, 5'b11111, 5'b11111, 5'b11111, 1'b0);
    send(OP_PASS, 3'b000, 5'b01101, 5'b10010, 5'b00000, 5'b01101, 1'b0);
    idle();
    wait_drain();
    check("done_cnt_13", 32'(done_cnt), 32'd13);

    // Backpressure: two accepted, third blocked
    out_ready = 1'b0;
    send(OP_AND, 3'b001, 5'b10110, 5'b00000, 5'b00000, 5'b10110, 1'b0);
    send(OP_OR, 3'b100, 5'b11111, 5'b11111, 5'b01001, 5'b01001, 1'b0);
    in_valid = 1'b1;
    in_op    = OP_NAND;
    in_mask  = 3'b010;
    in_data  = {5'b00000, 5'b00110, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_z", 32'(out_z), 32'(5'b10110));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(OP_NAND, 3'b010, 5'b00000, 5'b00110, 5'b00000, 5'b11001, 1'b0);
    idle();
    wait_drain();
    check("done_cnt_16", 32'(done_cnt), 32'd16);

    // Asynchronous reset mid-stall with two in flight
    out_ready = 1'b0;
    send(OP_XOR, 3'b111, 5'b00001, 5'b00010, 5'b00100, 5'b00111, 1'b0);
    send(OP_XOR, 3'b011, 5'b00001, 5'b00011, 5'b00100, 5'b00010, 1'b0);
    idle();
    @(negedge clk);
    check("pre_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_done_cnt", 32'(done_cnt), 32'd0);
    check("async_rst_done_cnt2", 32'(done_cnt2), 32'd0);
    check("async_rst_out_z", 32'(out_z), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    send(OP_OR, 3'b111, 5'b00001, 5'b00010, 5'b00100, 5'b00111, 1'b0);
    idle();
    wait_drain();
    check("post_rst_done_cnt", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gate_pipe.md
Name: gate_pipe

Overview:
Parametrised, pipelined multi-operand bitwise logic unit. It is the successor to the library's single-function two-input combinational gates. Each transaction carries NUM_IN operands of WIDTH bits, a per-operand enable mask and a runtime-selected operation; a registered result is produced. The unit sits between valid/ready producers and consumers in the gate library and is the building block for datapath logic stages.

Parameters:
WIDTH, 5, bit width of each operand and of the result
NUM_IN, 3, number of operands per transaction (>=2)
CNT_W, 8, width of the saturating completed-transaction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  input transaction valid
in_ready  out  1  unit can accept the input transaction
in_op  in  3  operation code
in_mask  in  NUM_IN  operand enable, bit k enables operand k
in_data  in  NUM_IN*WIDTH  packed operands, operand k at [k*WIDTH +: WIDTH]
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_z  out  WIDTH  result
out_err  out  1  result came from an illegal op code
done_cnt  out  CNT_W  saturating count of output transfers

Behaviour:
- Reset (rst_n=0, asynchronous): both stage valids=0, out_valid=0, out_z=0, out_err=0, done_cnt=0. In-flight transactions are discarded, not completed. in_ready is 1 whenever rst_n=1 and stage 1 is free.
- Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
- Stage 1 (S1) registers op, mask and data. Stage 2 (S2) registers the computed result and err. Latency: accept at edge N, out_valid=1 after edge N+1. Throughput is 1 per cycle with no backpressure.
- Ready chain: s2_free = !s2_valid || out_ready; in_ready = !s1_valid || s2_free. The combinational ready path is allowed.
- Stalls: when out_ready=0, S2 holds its contents. S1 holds when S2 is not free. out_z, out_err and out_valid stay stable while out_valid=1 and out_ready=0. Capacity is 2 transactions. Order is preserved with no drop and no duplicate.
- Op codes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS (operand 0, mask ignored), 7 illegal (z=0, err=1).
- Mask handling: a masked-off operand is replaced by the identity: all-ones for AND/NAND, zero for OR/NOR/XOR/XNOR. The inverted ops invert the reduced value.
- Mask all-zero gives the identity result: AND=all-ones, NAND=0, OR/XOR=0, NOR/XNOR=all-ones. out_err=0 in this case.
- out_err=0 for every op except 7.
- done_cnt increments by 1 per output transfer and saturates at 2^CNT_W-1. It never wraps.
- Simultaneous input and output transfer while full: S2 drains, S1 moves into S2, and the new input enters S1 in the same cycle.
- X on in_data while in_valid=0 does not propagate to the outputs.

Decomposition:
- Package gate_pkg: op code constants (OP_AND..OP_ILLEGAL) and OP_W=3. Shared with future gate blocks.
- One sub-module, gate_reduce (combinational): takes op, mask and packed data, returns z and err. It is parametrised by WIDTH and NUM_IN and is verified standalone.
- gate_pipe owns the two pipeline registers, the handshake logic and the counter.

Test Plan:
- WIDTH=5, NUM_IN=3, op=1 OR, data a=10100 b=00011 c=01000, mask=111, out_ready=1 -> out_valid one cycle after accept, out_z=11111, out_err=0, done_cnt=1.
- op=2 XOR, mask=101, a=10100 b=11111 c=01000 -> out_z=11100. Then op=3 NAND, mask=111, a=11111 b=11110 c=11111 -> out_z=00001.
- Back-to-back stream of 6 transactions with out_ready=1 -> 6 results on 6 consecutive cycles in order, done_cnt=6.
- out_ready=0 while 3 transactions are offered -> 2 accepted, in_ready=0, out_z held stable. Release out_ready -> all 3 delivered in order, none lost.
- op=7 -> out_z=00000, out_err=1. Mask=000 with op=0 -> out_z=11111. Mask=000 with op=4 -> out_z=11111. op=6, mask=000, a=01101 -> out_z=01101.
- rst_n pulled low asynchronously mid-stall with 2 transactions in flight -> out_valid=0 and done_cnt=0 immediately. After release, in_ready=1. With CNT_W=2, 5 transfers -> done_cnt=3.
